// File: rtl/pl_backend_pkg.sv
// Shared definitions for the PL backend frequency meter: FSM states,
// config-word field layout, result-word flag positions and width helpers.
package pl_backend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned WINDOW_LSB = 0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) result++;
    return result;
  endfunction

  // Select field is never narrower than one bit, even for a single input.
  function automatic int unsigned sel_width(input int unsigned num_inputs);
    return (clog2(num_inputs) == 0) ? 1 : clog2(num_inputs);
  endfunction

  function automatic int unsigned sel_lsb(input int unsigned window_width);
    return WINDOW_LSB + window_width;
  endfunction

  function automatic int unsigned overflow_bit(input int unsigned buffer_out_width);
    return buffer_out_width - 1;
  endfunction

  function automatic int unsigned sel_error_bit(input int unsigned buffer_out_width);
    return buffer_out_width - 2;
  endfunction

endpackage

// File: rtl/pl_backend_freq_meter_if.sv
// Frontend-to-backend handshake and data buffers; the frontend is the master.
interface pl_backend_freq_meter_if #(
  parameter int unsigned BUFFER_IN_WIDTH  = 32,
  parameter int unsigned BUFFER_OUT_WIDTH = 32
);
  logic                        sync;
  logic                        ack;
  logic [BUFFER_IN_WIDTH-1:0]  buffer_in;
  logic [BUFFER_OUT_WIDTH-1:0] buffer_out;

  modport master (output sync, output buffer_in, input ack, input buffer_out);
  modport slave  (input sync, input buffer_in, output ack, output buffer_out);
endinterface

// File: rtl/sync_edge_detector.sv
// Per-bit two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge_detector #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] pulse
);
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;
endmodule

// File: rtl/pl_backend_freq_meter.sv
// Counts rising edges of one selected asynchronous input over a programmable
// window of clock cycles and returns the result over the sync/ack handshake.
module pl_backend_freq_meter
  import pl_backend_pkg::*;
#(
  parameter int unsigned NUM_INPUTS       = 8,
  parameter int unsigned WINDOW_WIDTH     = 24,
  parameter int unsigned BUFFER_IN_WIDTH  = 32,
  parameter int unsigned BUFFER_OUT_WIDTH = 32
) (
  input logic                    clock,
  input logic                    reset,
  pl_backend_freq_meter_if.slave bus,
  input logic [NUM_INPUTS-1:0]   sig_in
);
  localparam int unsigned SEL_WIDTH   = sel_width(NUM_INPUTS);
  localparam int unsigned SEL_LSB     = sel_lsb(WINDOW_WIDTH);
  localparam int unsigned COUNT_WIDTH = BUFFER_OUT_WIDTH - 2;
  localparam int unsigned OVF_BIT     = overflow_bit(BUFFER_OUT_WIDTH);
  localparam int unsigned SEL_ERR_BIT = sel_error_bit(BUFFER_OUT_WIDTH);

  state_t                      state;
  logic                        armed;
  logic [WINDOW_WIDTH-1:0]     window_cnt;
  logic [SEL_WIDTH-1:0]        sel_q;
  logic [COUNT_WIDTH-1:0]      count;
  logic                        overflow;
  logic                        sel_error;
  logic                        ack;
  logic [BUFFER_OUT_WIDTH-1:0] buffer_out;
  logic [BUFFER_OUT_WIDTH-1:0] result;

  logic [NUM_INPUTS-1:0]   pulse;
  logic                    sel_pulse;
  logic [WINDOW_WIDTH-1:0] window_field;
  logic [SEL_WIDTH-1:0]    sel_field;
  logic                    sel_bad;
  logic                    unused_cfg_bits;

  sync_edge_detector #(.WIDTH(NUM_INPUTS)) u_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_in (sig_in),
    .pulse  (pulse)
  );

  assign window_field    = bus.buffer_in[WINDOW_LSB +: WINDOW_WIDTH];
  assign sel_field       = bus.buffer_in[SEL_LSB +: SEL_WIDTH];
  assign sel_bad         = 32'(sel_field) >= NUM_INPUTS;
  assign unused_cfg_bits = ^bus.buffer_in;

  always_comb begin
    sel_pulse = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (sel_q == SEL_WIDTH'(i)) sel_pulse = pulse[i];
    end
  end

  always_comb begin
    result                  = '0;
    result[COUNT_WIDTH-1:0] = count;
    result[SEL_ERR_BIT]     = sel_error;
    result[OVF_BIT]         = overflow;
  end

  // armed is only set by seeing sync low in IDLE, so a sync left high after
  // ack drops (or across reset) cannot retrigger a measurement.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      window_cnt <= '0;
      sel_q      <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      sel_error  <= 1'b0;
      ack        <= 1'b0;
      buffer_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (!bus.sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed      <= 1'b0;
            window_cnt <= window_field;
            sel_q      <= sel_field;
            count      <= '0;
            overflow   <= 1'b0;
            sel_error  <= sel_bad;
            state      <= (window_field == '0 || sel_bad) ? DONE : MEASURE;
          end
        end
        MEASURE: begin
          if (!bus.sync) begin
            state <= IDLE;
          end else begin
            window_cnt <= window_cnt - 1'b1;
            if (sel_pulse) begin
              if (count == '1) overflow <= 1'b1;
              else             count    <= count + 1'b1;
            end
            if (window_cnt == WINDOW_WIDTH'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (!ack) begin
            buffer_out <= result;
            if (bus.sync) ack   <= 1'b1;
            else          state <= IDLE;
          end else if (!bus.sync) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = ack;
  assign bus.buffer_out = buffer_out;
endmodule
